// File: rtl/aes_pkg.sv
// Shared AES constants and types for the 8-bit-datapath decryption round.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int INV_SR_LAT    = 13;
    localparam int SR_DEPTH      = 24;
    localparam int VLD_DEPTH     = INV_SR_LAT - 1;

    typedef logic [7:0] byte_t;

    // Delay-line tap used by each InvShiftRows output slot.
    localparam int unsigned INV_SR_TAP [AES_BLK_BYTES] = '{
        12, 0, 4, 8, 12, 16, 4, 8, 12, 16, 20, 8, 12, 16, 20, 24
    };

    function automatic logic [4:0] inv_sr_tap(input logic [3:0] slot);
        return 5'(INV_SR_TAP[slot]);
    endfunction

endpackage

// File: rtl/byte_delay_line.sv
// Free-running byte shift register; every stage is exported as a tap.
module byte_delay_line #(
    parameter int DEPTH = 24,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            din,
    output logic [DEPTH:1][W-1:0]   sr
);

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    // NOTE: the line is cleared on reset so no stale block bytes can surface after a mid-block reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-1:1], din};
        end
    end

endmodule

// File: rtl/inv_byte_permutation.sv
// Streaming InvShiftRows: column-major bytes in, inverse-row-shifted bytes out after 13 cycles.
module inv_byte_permutation
    import aes_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_first,
    output logic          dout_last,
    output logic          proto_err
);

    logic [SR_DEPTH:1][DW-1:0] sr;
    logic [VLD_DEPTH-1:0]      vld_pipe;
    logic                      vld_dly;
    logic [3:0]                in_cnt;
    logic [3:0]                out_cnt;
    logic [4:0]                tap_dly;
    logic [DW-1:0]             tap_byte;

    byte_delay_line #(
        .DEPTH (SR_DEPTH),
        .W     (DW)
    ) u_delay_line (
        .clk (clk),
        .rst (rst),
        .din (din),
        .sr  (sr)
    );

    assign vld_dly = vld_pipe[VLD_DEPTH-1];

    // Tap 0 is the live input; slot 1 needs the byte arriving in the same cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tap_dly  = inv_sr_tap(out_cnt);
        tap_byte = din;
        if (tap_dly != 5'd0) begin
            tap_byte = sr[tap_dly];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[VLD_DEPTH-2:0], din_valid};
            proto_err  <= !din_valid && (in_cnt != 4'd0);
            dout_valid <= vld_dly;
            dout_first <= vld_dly && (out_cnt == 4'd0);
            dout_last  <= vld_dly && (out_cnt == 4'd15);
            if (din_valid) begin
                in_cnt <= in_cnt + 4'd1;
            end
            // dout holds its last byte across idle cycles.
            if (vld_dly) begin
                dout    <= tap_byte;
                out_cnt <= out_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_byte_permutation.sv
// Scoreboard bench for inv_byte_permutation: directed blocks, gaps, protocol error, mid-block reset.
module tb_inv_byte_permutation;
    import aes_pkg::*;

    typedef struct {
        byte_t data;
        logic  first;
        logic  last;
        bit    chk_data;
        int    cyc;
    } exp_t;

    logic  clk;
    logic  rst;
    byte_t din;
    logic  din_valid;
    byte_t dout;
    logic  dout_valid;
    logic  dout_first;
    logic  dout_last;
    logic  proto_err;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    perr_cyc = -1;
    exp_t  sb[$];
    exp_t  mon_e;

    byte_t blk_a    [16];
    byte_t blk_b    [16];
    byte_t blk_fips [16];
    byte_t fips_in  [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                             8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    inv_byte_permutation #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source byte for output slot i from out[r][c] = in[r][(c-r) mod 4].
    function automatic int src_idx(input int i);
        int r = i % 4;
        int c = i / 4;
        return ((c - r + 4) % 4) * 4 + r;
    endfunction

    task automatic drive(input logic v, input byte_t d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // gap_at: insert one din_valid=0 cycle before that slot; abort_at: stop before that slot.
    task automatic send_block(input byte_t blk [16], input bit chk, input int gap_at, input int abort_at);
        int   start = cyc;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.data     = blk[src_idx(i)];
            e.first    = (i == 0);
            e.last     = (i == 15);
            e.chk_data = chk;
            e.cyc      = start + INV_SR_LAT + i + ((gap_at >= 0 && i >= gap_at) ? 1 : 0);
            sb.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) return;
            if (i == gap_at) begin
                perr_cyc = cyc + 1;
                drive(1'b0, 8'h00);
            end
            drive(1'b1, blk[i]);
        end
    endtask

    task automatic drain();
        din_valid = 1'b0;
        for (int k = 0; k < 64 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check("drain", sb.size(), 0);
        drive(1'b0, 8'h00);
    endtask

    task automatic chk_reset_state();
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout_first", dout_first, 1'b0);
        check("rst_dout_last", dout_last, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("proto_err", proto_err, (cyc == perr_cyc));
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", dout_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("slot_cycle", cyc, mon_e.cyc);
                    if (mon_e.chk_data) check("dout", dout, mon_e.data);
                    check("dout_first", dout_first, mon_e.first);
                    check("dout_last", dout_last, mon_e.last);
                end
            end else begin
                check("idle_first", dout_first, 1'b0);
                check("idle_last", dout_last, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_a[i]    = byte_t'(i);
            blk_b[i]    = byte_t'(8'h10 + i);
            blk_fips[i] = fips_in[i];
        end
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state();

        // Single block, then the FIPS-197 round-1 state.
        send_block(blk_a, 1'b1, -1, -1);
        drain();
        send_block(blk_fips, 1'b1, -1, -1);
        drain();

        // Back-to-back blocks at full rate.
        send_block(blk_a, 1'b1, -1, -1);
        send_block(blk_b, 1'b1, -1, -1);
        drain();

        // Five idle cycles between blocks.
        send_block(blk_a, 1'b1, -1, -1);
        repeat (5) drive(1'b0, 8'h00);
        send_block(blk_b, 1'b1, -1, -1);
        drain();

        // din_valid dropped with in_cnt == 6: framing still checked, data undefined.
        send_block(blk_a, 1'b0, 6, -1);
        drain();
        perr_cyc = -1;

        // Reset at input slot 9, then a clean block.
        send_block(blk_b, 1'b1, -1, 9);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        sb.delete();
        chk_reset_state();
        send_block(blk_fips, 1'b1, -1, -1);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_byte_permutation.md
Name: inv_byte_permutation

Overview:
- Streaming InvShiftRows for the 8-bit-datapath AES-128 decryption round.
- Accepts one state byte per cycle in column-major order (byte i = row i%4, col i/4) and emits the same 16 bytes reordered so that out[r][c] = in[r][(c-r) mod 4].
- Sits between the AddRoundKey/InvMixColumns stage and the InvSubBytes stage.
- Generates its own tap selection from internal counters; no external select input.

Parameters:
- DW, 8, byte lane width. Must stay 8 for AES; parameterised for bench reuse only.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- din  input  DW  input state byte
- din_valid  input  1  byte on din is accepted this cycle
- dout  output  DW  permuted output byte, registered
- dout_valid  output  1  dout holds a valid byte
- dout_first  output  1  dout is output slot 0 of a block
- dout_last  output  1  dout is output slot 15 of a block
- proto_err  output  1  one-cycle pulse: din_valid dropped mid-block

Behaviour:
- Reset (rst=1 at posedge):
  - Clears a 24-stage DW-bit delay line sr[1..24], all counters and all output registers.
  - Next cycle: dout=0, dout_valid=0, dout_first=0, dout_last=0, proto_err=0.
  - Reset mid-block discards all partial input and output; no residual valid bytes appear after reset.
- Delay line:
  - Shifts every cycle, regardless of din_valid: sr[1]<=din, sr[k]<=sr[k-1].
  - Tap 0 = din (combinational); taps 4, 8, 12, 16, 20, 24 = sr[k].
- Input counter in_cnt (4 bit):
  - Increments on din_valid; wraps 15->0.
  - A block is 16 consecutive din_valid cycles. Gaps are allowed only between blocks (in_cnt==0). Back-to-back blocks are supported at full rate.
- Protocol error:
  - din_valid=0 while in_cnt!=0: proto_err pulses 1 the following cycle.
  - in_cnt holds; bytes taken around the gap produce undefined dout data.
  - Valid/first/last framing stays 16 cycles per block as counted.
- Valid pipeline:
  - A 12-deep shift of din_valid feeds an output slot counter out_cnt (4 bit).
  - out_cnt increments when the delayed valid is 1; wraps 15->0.
- Latency and ordering:
  - Byte accepted in cycle 0 as block slot 0 produces dout in cycle 13.
  - Output slot i appears in cycle 13+i.
  - Source input index per slot: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
  - Tap delay per slot (tap = 12+i-src): 12,0,4,8,12,16,4,8,12,16,20,8,12,16,20,24.
  - dout <= tap[sel(out_cnt)] when delayed valid is 1.
  - dout_first = (out_cnt==0); dout_last = (out_cnt==15); both qualified with dout_valid.
- Idle output:
  - When the delayed valid is 0: dout_valid=0, dout_first=0, dout_last=0.
  - dout holds its last value (no forced zero).
- Slot 15 boundary: slot 15 uses tap 24, i.e. the delay line still holds the block's byte 3 while the next block streams in. Overlapping blocks therefore need no stall.

Decomposition:
- aes_pkg gets:
  - AES_BLK_BYTES=16
  - INV_SR_LAT=13
  - INV_SR_TAP[16] constant array (delays above)
  - typedef byte_t
- One sub-module: byte_delay_line (parameter DEPTH=24, W=DW, synchronous reset, exports all stages).
- Counters and the tap mux stay in the top.

Test Plan:
- Single block din=0x00..0x0F from cycle 0 -> dout_valid cycles 13..28, dout = 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. dout_first at cycle 13, dout_last at cycle 28.
- FIPS-197 App. B round 1: din = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5 -> dout = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Back-to-back blocks 0x00..0x0F then 0x10..0x1F -> 32 contiguous valid cycles. Second block = 10 1D 1A 17 14 11 1E 1B 18 15 12 1F 1C 19 16 13; no bubble.
- 5-cycle gap between two blocks -> outputs separated by exactly 5 invalid cycles, both blocks correct, proto_err never asserted.
- din_valid low at in_cnt=6 -> proto_err=1 for exactly one cycle, one cycle later.
- rst asserted at input slot 9, then a new clean block -> no dout_valid until 13 cycles after the new block's first byte; new block is correct.
